pwm_generator: RTL and testbench

//  Runtime-programmable PWM stage. Its internal modulo counter counts 0..period, and a registered compare

---
 rtl/pwm_pkg.sv | 11 +
 rtl/pwm_shadow_reg.sv | 50 +++++
 rtl/pwm_generator.sv | 93 +++++++++
 tb/tb_pwm_generator.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM stage: counting direction encoding and default width.
package pwm_pkg;

  localparam int BITS_DEFAULT = 8;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/pwm_shadow_reg.sv
// Staging and shadow registers for period/duty; new values reach the shadows only at a
// period boundary, with a direct bypass when the load lands on the boundary edge itself.
module pwm_shadow_reg
  import pwm_pkg::*;
#(
  parameter int BITS = BITS_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            boundary,
  input  logic [BITS-1:0] period,
  input  logic [BITS-1:0] duty,
  output logic [BITS-1:0] period_sh,
  output logic [BITS-1:0] duty_sh,
  output logic            load_pending
);

  logic [BITS-1:0] period_stg;
  logic [BITS-1:0] duty_stg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_stg   <= '0;
      duty_stg     <= '0;
      period_sh    <= '0;
      duty_sh      <= '0;
      load_pending <= 1'b0;
    end else begin
      if (load) begin
        period_stg <= period;
        duty_stg   <= duty;
      end
      if (boundary) begin
        // A load coinciding with the boundary is newer than anything staged.
        if (load) begin
          period_sh <= period;
          duty_sh   <= duty;
        end else if (load_pending) begin
          period_sh <= period_stg;
          duty_sh   <= duty_stg;
        end
        load_pending <= 1'b0;
      end else if (load) begin
        load_pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwm_generator.sv
// Tick-paced PWM with glitch-free period/duty updates; center-aligned (up/down) counting
// is available when PWM_CENTER_ALIGNED_EN is defined, otherwise edge-aligned only.
module pwm_generator
  import pwm_pkg::*;
#(
  parameter int BITS = BITS_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [BITS-1:0] period,
  input  logic [BITS-1:0] duty,
  input  logic            load,
  output logic            load_pending,
  output logic [BITS-1:0] cnt,
  output logic            pwm_out,
  output logic            period_done
);

  logic [BITS-1:0] period_sh;
  logic [BITS-1:0] duty_sh;
  logic            boundary;

  pwm_shadow_reg #(.BITS(BITS)) u_shadow (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .boundary     (boundary),
    .period       (period),
    .duty         (duty),
    .period_sh    (period_sh),
    .duty_sh      (duty_sh),
    .load_pending (load_pending)
  );

`ifdef PWM_CENTER_ALIGNED_EN
  dir_t dir;

  // period_sh==1 never enters the down leg, so its wrap is taken from cnt==1 while still going up.
  always_comb begin
    boundary = 1'b0;
    if (enable) begin
      if (period_sh == '0)
        boundary = 1'b1;
      else if (cnt == BITS'(1) && (dir == DIR_DOWN || period_sh == BITS'(1)))
        boundary = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      dir <= DIR_UP;
    end else if (boundary) begin
      cnt <= '0;
      dir <= DIR_UP;
    end else if (enable) begin
      if (dir == DIR_UP) begin
        if (cnt >= period_sh) begin
          cnt <= cnt - BITS'(1);
          dir <= DIR_DOWN;
        end else begin
          cnt <= cnt + BITS'(1);
        end
      end else begin
        cnt <= cnt - BITS'(1);
      end
    end
  end
`else
  assign boundary = enable && (cnt == period_sh);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (boundary)
      cnt <= '0;
    else if (enable)
      cnt <= cnt + BITS'(1);
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_out     <= 1'b0;
      period_done <= 1'b0;
    end else begin
      pwm_out     <= (cnt < duty_sh);
      period_done <= boundary;
    end
  end

endmodule

// File: tb/tb_pwm_generator.sv
// Directed self-checking bench for pwm_generator; center-aligned scenario runs only
// when PWM_CENTER_ALIGNED_EN is defined.
module tb_pwm_generator;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] period = '0;
  logic [7:0] duty = '0;
  logic       load = 1'b0;
  logic       load_pending;
  logic [7:0] cnt;
  logic       pwm_out;
  logic       period_done;

  int pass_cnt = 0;
  int total_cnt = 0;

  pwm_generator #(.BITS(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .period       (period),
    .duty         (duty),
    .load         (load),
    .load_pending (load_pending),
    .cnt          (cnt),
    .pwm_out      (pwm_out),
    .period_done  (period_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; load = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // First enabled edge after reset is a boundary, so this load bypasses straight to the shadows.
  task automatic prime(input logic [7:0] p, input logic [7:0] d);
    period = p; duty = d; load = 1'b1; enable = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if ({cnt, pwm_out, period_done, load_pending} !== 11'd0)
      $display("FAIL reset_state got cnt=%0d pwm=%0b pd=%0b lp=%0b want all 0",
               cnt, pwm_out, period_done, load_pending);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [7:0] exp_cnt [10] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
    logic       exp_pwm [10] = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0};
    logic       exp_pd  [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    do_reset();
    prime(8'd4, 8'd2);
    total_cnt++;
    if (cnt !== 8'd0 || period_done !== 1'b1 || load_pending !== 1'b0)
      $display("FAIL basic_bypass got cnt=%0d pd=%0b lp=%0b want 0 1 0", cnt, period_done, load_pending);
    else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      tick();
      total_cnt++;
      if (cnt !== exp_cnt[i] || pwm_out !== exp_pwm[i] || period_done !== exp_pd[i])
        $display("FAIL basic[%0d] got cnt=%0d pwm=%0b pd=%0b want %0d %0b %0b",
                 i, cnt, pwm_out, period_done, exp_cnt[i], exp_pwm[i], exp_pd[i]);
      else pass_cnt++;
    end
  endtask

  // Continues from test_basic: cnt=0, period 4, duty 2.
  task automatic test_staged_load();
    logic exp_pwm [6] = '{0, 0, 1, 1, 1, 1};
    logic exp_lp  [6] = '{1, 0, 0, 0, 0, 0};
    int   highs = 0;
    tick(); tick();
    period = 8'd4; duty = 8'd4; load = 1'b1;
    tick();
    load = 1'b0;
    total_cnt++;
    if (load_pending !== 1'b1 || cnt !== 8'd3 || pwm_out !== 1'b0)
      $display("FAIL staged_pending got lp=%0b cnt=%0d pwm=%0b want 1 3 0", load_pending, cnt, pwm_out);
    else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i >= 2) highs += int'(pwm_out);
      total_cnt++;
      if (pwm_out !== exp_pwm[i] || load_pending !== exp_lp[i])
        $display("FAIL staged[%0d] got pwm=%0b lp=%0b want %0b %0b",
                 i, pwm_out, load_pending, exp_pwm[i], exp_lp[i]);
      else pass_cnt++;
    end
    tick();
    highs += int'(pwm_out);
    total_cnt++;
    if (highs != 4)
      $display("FAIL staged_high_count got %0d want 4", highs);
    else pass_cnt++;
  endtask

  task automatic test_duty_limits();
    do_reset();
    prime(8'd4, 8'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      total_cnt++;
      if (pwm_out !== 1'b0 || cnt !== 8'(i + 1))
        $display("FAIL duty0[%0d] got pwm=%0b cnt=%0d want 0 %0d", i, pwm_out, cnt, i + 1);
      else pass_cnt++;
    end
    period = 8'd4; duty = 8'd9; load = 1'b1;
    tick();
    load = 1'b0;
    total_cnt++;
    if (cnt !== 8'd0 || period_done !== 1'b1 || load_pending !== 1'b0 || pwm_out !== 1'b0)
      $display("FAIL boundary_load got cnt=%0d pd=%0b lp=%0b pwm=%0b want 0 1 0 0",
               cnt, period_done, load_pending, pwm_out);
    else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      tick();
      total_cnt++;
      if (pwm_out !== 1'b1)
        $display("FAIL duty9[%0d] got pwm=%0b want 1", i, pwm_out);
      else pass_cnt++;
    end
  endtask

  task automatic test_enable_toggle();
    int         adv = 0;
    logic [7:0] exp_cnt;
    logic       exp_pd;
    do_reset();
    prime(8'd4, 8'd2);
    for (int k = 0; k < 20; k++) begin
      enable = (k % 2 == 1);
      tick();
      exp_pd = 1'b0;
      if (k % 2 == 1) begin
        adv++;
        exp_pd = (adv % 5 == 0);
      end
      exp_cnt = 8'(adv % 5);
      total_cnt++;
      if (cnt !== exp_cnt || period_done !== exp_pd)
        $display("FAIL toggle[%0d] got cnt=%0d pd=%0b want %0d %0b", k, cnt, period_done, exp_cnt, exp_pd);
      else pass_cnt++;
    end
    enable = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    prime(8'd4, 8'd2);
    tick(); tick();
    period = 8'd7; duty = 8'd3; load = 1'b1;
    tick();
    load = 1'b0;
    total_cnt++;
    if (cnt !== 8'd3 || load_pending !== 1'b1)
      $display("FAIL mid_setup got cnt=%0d lp=%0b want 3 1", cnt, load_pending);
    else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    total_cnt++;
    if ({cnt, pwm_out, period_done, load_pending} !== 11'd0)
      $display("FAIL mid_async got cnt=%0d pwm=%0b pd=%0b lp=%0b want all 0",
               cnt, pwm_out, period_done, load_pending);
    else pass_cnt++;
    enable = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if (cnt !== 8'd0 || period_done !== 1'b0)
        $display("FAIL mid_hold[%0d] got cnt=%0d pd=%0b want 0 0", i, cnt, period_done);
      else pass_cnt++;
    end
    // Discarded load means the shadow period is still 0: every enabled tick wraps.
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if (cnt !== 8'd0 || period_done !== 1'b1 || pwm_out !== 1'b0)
        $display("FAIL mid_discard[%0d] got cnt=%0d pd=%0b pwm=%0b want 0 1 0",
                 i, cnt, period_done, pwm_out);
      else pass_cnt++;
    end
    enable = 1'b0;
  endtask

`ifdef PWM_CENTER_ALIGNED_EN
  task automatic test_center();
    logic [7:0] exp_cnt [12] = '{1, 2, 3, 2, 1, 0, 1, 2, 3, 2, 1, 0};
    logic       exp_pwm [12] = '{1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1};
    logic       exp_pd  [12] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
    do_reset();
    prime(8'd3, 8'd2);
    for (int i = 0; i < 12; i++) begin
      tick();
      total_cnt++;
      if (cnt !== exp_cnt[i] || pwm_out !== exp_pwm[i] || period_done !== exp_pd[i])
        $display("FAIL center[%0d] got cnt=%0d pwm=%0b pd=%0b want %0d %0b %0b",
                 i, cnt, pwm_out, period_done, exp_cnt[i], exp_pwm[i], exp_pd[i]);
      else pass_cnt++;
    end
    enable = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
`ifdef PWM_CENTER_ALIGNED_EN
    test_center();
`else
    test_basic();
    test_staged_load();
    test_duty_limits();
    test_enable_toggle();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
